// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. Round-robin between requesters 0 and 1.
// Writes complete in a single strobe cycle and allow back-to-back grants.
// Reads block further grants until the data has been returned, RD_LAT cycles
// after the read strobe.
module mem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [1:0] addr,
    output logic       wr_en,
    output logic       rd_en,
    output logic [7:0] wdata,
    input  logic [7:0] rdata
);

    localparam logic [1:0] LAT = 2'(RD_LAT);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;          // cycles elapsed since the read strobe
    logic       last, last_nxt;        // 1 = requester 1 was granted most recently
    logic       owner, owner_nxt;      // requester that issued the pending read
    logic       gnt0_nxt, gnt1_nxt, wr_nxt, rd_nxt, rv0_nxt, rv1_nxt;
    logic [1:0] addr_nxt;
    logic [7:0] wdata_nxt;
    logic       el0, el1, pick1, we_sel;

    // Next-state, arbitration and registered-output precompute
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        owner_nxt = owner;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        wr_nxt    = 1'b0;
        rd_nxt    = 1'b0;
        rv0_nxt   = 1'b0;
        rv1_nxt   = 1'b0;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        // A requester currently seeing its grant is still holding req this
        // cycle; masking it prevents granting the same request twice.
        el0       = req0 & ~gnt0;
        el1       = req1 & ~gnt1;
        pick1     = el1 & (~el0 | ~last);
        we_sel    = pick1 ? we1 : we0;
        case (state)
            IDLE: begin
                if (el0 | el1) begin
                    gnt0_nxt  = ~pick1;
                    gnt1_nxt  = pick1;
                    last_nxt  = pick1;
                    addr_nxt  = pick1 ? addr1 : addr0;
                    wdata_nxt = pick1 ? wdata1 : wdata0;
                    if (we_sel) begin
                        wr_nxt = 1'b1;
                    end else begin
                        rd_nxt    = 1'b1;
                        state_nxt = RD_WAIT;
                        cnt_nxt   = 2'd0;
                        owner_nxt = pick1;
                    end
                end
            end
            RD_WAIT: begin
                // Memory data is valid while cnt == LAT; it is captured at the
                // end of that cycle and presented with rvalid the next one.
                if (cnt == LAT) begin
                    state_nxt = IDLE;
                    rv0_nxt   = ~owner;
                    rv1_nxt   = owner;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            last    <= 1'b1;
            owner   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            addr    <= 2'd0;
            wdata   <= 8'd0;
            rdata0  <= 8'd0;
            rdata1  <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            owner   <= owner_nxt;
            gnt0    <= gnt0_nxt;
            gnt1    <= gnt1_nxt;
            wr_en   <= wr_nxt;
            rd_en   <= rd_nxt;
            rvalid0 <= rv0_nxt;
            rvalid1 <= rv1_nxt;
            addr    <= addr_nxt;
            wdata   <= wdata_nxt;
            if (rv0_nxt) rdata0 <= rdata;
            if (rv1_nxt) rdata1 <= rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table on an RD_LAT=1 instance plus
// a hand-written read sequence on an RD_LAT=3 instance.
module tb_mem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: RD_LAT = 1
    logic       a_rst, a_req0, a_req1, a_we0, a_we1;
    logic [1:0] a_addr0, a_addr1, a_addr;
    logic [7:0] a_wdata0, a_wdata1, a_wdata, a_rdata, a_rdata0, a_rdata1;
    logic       a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_wr_en, a_rd_en;

    // Instance B: RD_LAT = 3
    logic       b_rst, b_req0, b_req1, b_we0, b_we1;
    logic [1:0] b_addr0, b_addr1, b_addr;
    logic [7:0] b_wdata0, b_wdata1, b_wdata, b_rdata, b_rdata0, b_rdata1;
    logic       b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_wr_en, b_rd_en;

    mem_arbiter #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(a_rst), .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
        .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
        .rdata0(a_rdata0), .rdata1(a_rdata1), .addr(a_addr), .wr_en(a_wr_en),
        .rd_en(a_rd_en), .wdata(a_wdata), .rdata(a_rdata)
    );

    mem_arbiter #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(b_rst), .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata0(b_rdata0), .rdata1(b_rdata1), .addr(b_addr), .wr_en(b_wr_en),
        .rd_en(b_rd_en), .wdata(b_wdata), .rdata(b_rdata)
    );

    typedef struct {
        logic        rst;
        logic        r0, w0;
        logic [1:0]  a0;
        logic [7:0]  d0;
        logic        r1, w1;
        logic [1:0]  a1;
        logic [7:0]  d1;
        logic [7:0]  mrd;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];
    int   nv = 0;
    int   total = 0;
    int   bad = 0;

    // Output word: {gnt0,gnt1,rvalid0,rvalid1,wr_en,rd_en,addr,wdata,rdata0,rdata1}
    function automatic logic [31:0] pk(input logic g0, g1, v0, v1, w, r,
                                       input logic [1:0] a, input logic [7:0] wd, d0, d1);
        return {g0, g1, v0, v1, w, r, a, wd, d0, d1};
    endfunction

    task automatic addv(input logic rst, r0, w0, input logic [1:0] a0, input logic [7:0] d0,
                        input logic r1, w1, input logic [1:0] a1, input logic [7:0] d1,
                        input logic [7:0] mrd, input logic [31:0] exp);
        tbl[nv] = '{rst, r0, w0, a0, d0, r1, w1, a1, d1, mrd, exp};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_a();
        return {a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_wr_en, a_rd_en, a_addr, a_wdata, a_rdata0, a_rdata1};
    endfunction

    function automatic logic [31:0] out_b();
        return {b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_wr_en, b_rd_en, b_addr, b_wdata, b_rdata0, b_rdata1};
    endfunction

    initial begin
        logic [31:0] e;
        // reset; write request during reset ignored
        addv(H, H,H,2'd2,8'hA5, L,L,2'd0,8'h00, 8'h00, pk(L,L,L,L,L,L,2'd0,8'h00,8'h00,8'h00));
        // single write
        addv(L, H,H,2'd2,8'hA5, L,L,2'd0,8'h00, 8'h00, pk(H,L,L,L,H,L,2'd2,8'hA5,8'h00,8'h00));
        addv(L, L,L,2'd0,8'h00, L,L,2'd0,8'h00, 8'h00, pk(L,L,L,L,L,L,2'd2,8'hA5,8'h00,8'h00));
        // single read from requester 1, memory returns 3C one cycle after rd_en
        addv(L, L,L,2'd0,8'h00, H,L,2'd3,8'h11, 8'h00, pk(L,H,L,L,L,H,2'd3,8'h11,8'h00,8'h00));
        addv(L, L,L,2'd0,8'h00, L,L,2'd0,8'h00, 8'h99, pk(L,L,L,L,L,L,2'd3,8'h11,8'h00,8'h00));
        addv(L, L,L,2'd0,8'h00, L,L,2'd0,8'h00, 8'h3C, pk(L,L,L,H,L,L,2'd3,8'h11,8'h00,8'h3C));
        addv(L, L,L,2'd0,8'h00, L,L,2'd0,8'h00, 8'h77, pk(L,L,L,L,L,L,2'd3,8'h11,8'h00,8'h3C));
        // reset, then held contention: 0 first, then alternation
        addv(H, L,L,2'd0,8'h00, H,H,2'd1,8'hF0, 8'h00, pk(L,L,L,L,L,L,2'd0,8'h00,8'h00,8'h00));
        addv(L, H,H,2'd1,8'h10, H,H,2'd2,8'h20, 8'h00, pk(H,L,L,L,H,L,2'd1,8'h10,8'h00,8'h00));
        addv(L, H,H,2'd1,8'h10, H,H,2'd2,8'h20, 8'h00, pk(L,H,L,L,H,L,2'd2,8'h20,8'h00,8'h00));
        addv(L, H,H,2'd1,8'h10, H,H,2'd2,8'h20, 8'h00, pk(H,L,L,L,H,L,2'd1,8'h10,8'h00,8'h00));
        addv(L, H,H,2'd1,8'h10, H,H,2'd2,8'h20, 8'h00, pk(L,H,L,L,H,L,2'd2,8'h20,8'h00,8'h00));
        // read by 0 blocks pending write by 1 until after rvalid0
        addv(L, H,L,2'd0,8'h55, L,L,2'd0,8'h00, 8'h00, pk(H,L,L,L,L,H,2'd0,8'h55,8'h00,8'h00));
        addv(L, L,L,2'd0,8'h00, H,H,2'd3,8'h66, 8'h00, pk(L,L,L,L,L,L,2'd0,8'h55,8'h00,8'h00));
        addv(L, L,L,2'd0,8'h00, H,H,2'd3,8'h66, 8'hC3, pk(L,L,H,L,L,L,2'd0,8'h55,8'hC3,8'h00));
        addv(L, L,L,2'd0,8'h00, H,H,2'd3,8'h66, 8'h00, pk(L,H,L,L,H,L,2'd3,8'h66,8'hC3,8'h00));
        addv(L, L,L,2'd0,8'h00, L,L,2'd0,8'h00, 8'h00, pk(L,L,L,L,L,L,2'd3,8'h66,8'hC3,8'h00));
        // reset the cycle after rd_en: read abandoned
        addv(L, H,L,2'd1,8'h01, L,L,2'd0,8'h00, 8'h00, pk(H,L,L,L,L,H,2'd1,8'h01,8'hC3,8'h00));
        addv(H, L,L,2'd0,8'h00, L,L,2'd0,8'h00, 8'hAB, pk(L,L,L,L,L,L,2'd0,8'h00,8'h00,8'h00));
        addv(L, L,L,2'd0,8'h00, L,L,2'd0,8'h00, 8'hAB, pk(L,L,L,L,L,L,2'd0,8'h00,8'h00,8'h00));
        addv(L, H,H,2'd3,8'h5A, L,L,2'd0,8'h00, 8'h00, pk(H,L,L,L,H,L,2'd3,8'h5A,8'h00,8'h00));
        addv(L, L,L,2'd0,8'h00, L,L,2'd0,8'h00, 8'h00, pk(L,L,L,L,L,L,2'd3,8'h5A,8'h00,8'h00));
        // lone requester 1 wins
        addv(L, L,L,2'd0,8'h00, H,H,2'd0,8'h0F, 8'h00, pk(L,H,L,L,H,L,2'd0,8'h0F,8'h00,8'h00));

        b_rst = H; b_req0 = L; b_req1 = L; b_we0 = L; b_we1 = L;
        b_addr0 = 2'd0; b_addr1 = 2'd0; b_wdata0 = 8'h00; b_wdata1 = 8'h00; b_rdata = 8'h00;

        for (int i = 0; i < nv; i++) begin
            a_rst = tbl[i].rst;
            a_req0 = tbl[i].r0; a_we0 = tbl[i].w0; a_addr0 = tbl[i].a0; a_wdata0 = tbl[i].d0;
            a_req1 = tbl[i].r1; a_we1 = tbl[i].w1; a_addr1 = tbl[i].a1; a_wdata1 = tbl[i].d1;
            a_rdata = tbl[i].mrd;
            @(posedge clk);
            #1;
            chk($sformatf("lat1_vec%0d", i), out_a(), tbl[i].exp);
        end

        // RD_LAT=3: read by 1, write by 0 pending throughout the wait
        @(posedge clk);
        #1;
        chk("lat3_reset", out_b(), pk(L,L,L,L,L,L,2'd0,8'h00,8'h00,8'h00));
        b_rst = L; b_req1 = H; b_we1 = L; b_addr1 = 2'd2;
        @(posedge clk);
        #1;
        chk("lat3_rd_en", out_b(), pk(L,H,L,L,L,H,2'd2,8'h00,8'h00,8'h00));
        b_req1 = L; b_req0 = H; b_we0 = H; b_addr0 = 2'd1; b_wdata0 = 8'h99;
        for (int k = 0; k < 6; k++) begin
            b_rdata = 8'h40 + 8'(k);
            if (k == 5) b_req0 = L;
            @(posedge clk);
            #1;
            case (k)
                3:       e = pk(L,L,L,H,L,L,2'd2,8'h00,8'h00,8'h43);
                4:       e = pk(H,L,L,L,H,L,2'd1,8'h99,8'h00,8'h43);
                5:       e = pk(L,L,L,L,L,L,2'd1,8'h99,8'h00,8'h43);
                default: e = pk(L,L,L,L,L,L,2'd2,8'h00,8'h00,8'h00);
            endcase
            chk($sformatf("lat3_step%0d", k + 1), out_b(), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: RD_LAT, default 1, memory read latency in cycles from rd_en to rdata valid (legal 1..3).
REQ-002 SHALL have a single clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  access request, requester 0 and 1.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0, addr1  input  2 each  word address; valid while reqN high.
REQ-008 wdata0, wdata1  input  8 each  write data; valid while reqN high.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulse.
REQ-010 rvalid0, rvalid1  output  1 each  one-cycle read-data-valid pulse.
REQ-011 rdata0, rdata1  output  8 each  read data returned to requester.
REQ-012 addr  output  2  memory address.
REQ-013 wr_en  output  1  memory write strobe.
REQ-014 rd_en  output  1  memory read strobe.
REQ-015 wdata  output  8  memory write data.
REQ-016 rdata  input  8  memory read data, valid RD_LAT cycles after rd_en.

Function
REQ-017 SHALL implement FSM states IDLE and RD_WAIT.
REQ-018 In IDLE, a req sampled high in cycle N SHALL produce, in cycle N+1, exactly one registered gnt pulse plus memory strobe, addr and wdata from the granted requester.
REQ-019 Write grant: wr_en=1, rd_en=0 for one cycle; FSM stays IDLE; back-to-back grants (one per cycle) SHALL be allowed.
REQ-020 Read grant: rd_en=1, wr_en=0 for one cycle; FSM enters RD_WAIT.
REQ-021 RD_WAIT: count RD_LAT cycles; capture memory rdata in cycle N+1+RD_LAT; rvalidK=1 with rdataK in cycle N+2+RD_LAT; return to IDLE that cycle.
REQ-022 No grant SHALL issue while in RD_WAIT; requests pend and are arbitrated from the IDLE cycle onward.
REQ-023 Requester holds req/we/addr/wdata stable until gnt; the req of a requester whose gnt is high in the current cycle SHALL be ignored for arbitration (no double grant).
REQ-024 Arbitration SHALL be round-robin: when both request, grant the requester not granted last; single requester always wins.
REQ-025 gnt0/gnt1 SHALL be mutually exclusive; wr_en and rd_en SHALL never be high together.
REQ-026 rdataK SHALL change only in a cycle with rvalidK=1 and hold otherwise.
REQ-027 addr and wdata SHALL hold last driven value when no strobe is active.
REQ-028 rvalid SHALL go only to the requester that issued the read.

Reset
REQ-029 With rst high at a clock edge: FSM=IDLE, round-robin priority favours requester 0, all gnt/rvalid/wr_en/rd_en=0, addr=0, wdata=0, rdata0=rdata1=0.
REQ-030 Reset during RD_WAIT SHALL abandon the read; no rvalid issues for it.
REQ-031 Requests sampled in the cycle rst is high SHALL be ignored.

Verification
REQ-032 Single write: req0=1,we0=1,addr0=2,wdata0=8'hA5 -> next cycle gnt0=1, wr_en=1, addr=2, wdata=8'hA5; rd_en=0.
REQ-033 Single read, RD_LAT=1: req1=1,we1=0,addr1=3 at cycle N; memory returns 8'h3C -> gnt1 and rd_en at N+1, rvalid1=1, rdata1=8'h3C at N+3; rvalid0 stays 0.
REQ-034 Contention after reset: req0=req1=1 writes held -> gnt0 first, gnt1 next cycle, then alternation; never both grants high.
REQ-035 Read blocking: req0 read granted, req1 write pending -> no gnt1 until read completes; gnt1 issues the cycle after rvalid0.
REQ-036 Reset mid-read: assert rst in the cycle after rd_en -> no rvalid; all outputs 0 next cycle; a new req0 then grants requester 0.
REQ-037 RD_LAT=3 read -> rvalid exactly 4 cycles after rd_en, data matches memory rdata sampled 3 cycles after rd_en.
